switch_debounce_conditioner: RTL and testbench

- Conditions the raw DE0-Nano slide-switch inputs before they reach the Nios system's switches_export PIO port.
- Per-bit processing: 2-flop synchronisation, prescaled-tick debounce and edge detection.
- Produces one-cycle rise and fall pulses, plus a sticky change flag with a clear input, so software or the LED logic can react to validated edges.
- Sits directly upstream of the system's switches_export input and shares its clock domain.

---
 rtl/switch_debounce_conditioner.sv | 103 ++++++++++
 tb/tb_switch_debounce_conditioner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_conditioner.sv
// rtl/switch_debounce_conditioner.sv - slide-switch synchroniser, tick-based debounce and edge detector
module switch_debounce_conditioner #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switches_export,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed,
  input  logic             clr_changed,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         meta_q, meta_d;
  logic [WIDTH-1:0]         sync_q, sync_d;
  logic [PW-1:0]            pre_q, pre_d;
  logic                     tick_q, tick_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         db_q, db_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic                     changed_q, changed_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  // Tick is registered so it is high exactly while the prescaler sits at its last count.
  always_comb begin
    meta_d = sw_raw;
    sync_d = meta_q;
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    tick_d = (pre_d == PRE_LAST);
  end

  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]   = sync_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync_q[i];
          fall_d[i] = ~sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // A pulse being registered overrides a simultaneous clear.
  always_comb begin
    if ((|rise_d) || (|fall_d)) begin
      changed_d = 1'b1;
    end else if (clr_changed) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end
  end

  assign switches_export = db_q;
  assign sw_rise         = rise_q;
  assign sw_fall         = fall_q;
  assign changed         = changed_q;
  assign tick            = tick_q;

endmodule

// File: tb/tb_switch_debounce_conditioner.sv
// tb/tb_switch_debounce_conditioner.sv - directed self-checking bench for switch_debounce_conditioner
module tb_switch_debounce_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw_raw;
  logic [7:0] switches_export;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       changed;
  logic       clr_changed;
  logic       tick;

  int total = 0;
  int bad   = 0;

  switch_debounce_conditioner #(
    .WIDTH(8),
    .TICK_DIV(4),
    .STABLE_TICKS(3)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .sw_raw(sw_raw),
    .switches_export(switches_export),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed),
    .clr_changed(clr_changed),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_export(input logic [7:0] target, output int n, output logic [7:0] r,
                             output logic [7:0] f, output logic c, output logic pc);
    n  = -1;
    r  = '0;
    f  = '0;
    c  = 1'b0;
    pc = changed;
    for (int k = 1; k <= 40; k++) begin
      pc = changed;
      step();
      if (switches_export == target) begin
        n = k;
        r = sw_rise;
        f = sw_fall;
        c = changed;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_export"}, 32'(switches_export), 32'h0);
    chk({tag, "_pulses"}, 32'({sw_rise, sw_fall}), 32'h0);
    chk({tag, "_flags"}, 32'({changed, tick}), 32'h0);
  endtask

  int         n;
  logic [7:0] r, f;
  logic       c, pc;
  logic [7:0] acc_x;
  logic       acc_c;
  int         nticks, last_tick, spacing_bad;

  initial begin
    rst_n       = 1'b0;
    sw_raw      = 8'h00;
    clr_changed = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // 1: idle
    acc_x = '0; acc_c = 1'b0; nticks = 0; last_tick = -1; spacing_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      acc_x |= switches_export | sw_rise | sw_fall;
      acc_c |= changed;
      if (tick) begin
        nticks++;
        if (last_tick >= 0 && (i - last_tick) != 4) spacing_bad++;
        last_tick = i;
      end
    end
    chk("idle_outputs", 32'(acc_x), 32'h0);
    chk("idle_changed", 32'(acc_c), 32'h0);
    chk("idle_tick_count", 32'(nticks), 32'd25);
    chk("idle_tick_spacing", 32'(spacing_bad), 32'd0);

    // 2: clean step
    sw_raw = 8'h81;
    wait_export(8'h81, n, r, f, c, pc);
    chk("step_latency_ok", 32'(n >= 11 && n <= 15), 32'd1);
    chk("step_rise", 32'(r), 32'h81);
    chk("step_fall", 32'(f), 32'h00);
    chk("step_changed", 32'(c), 32'd1);
    step();
    chk("step_rise_one_cycle", 32'(sw_rise), 32'h00);
    chk("step_changed_held", 32'(changed), 32'd1);

    // 3: bounce on bit 2
    acc_x = '0;
    for (int i = 0; i < 200; i++) begin
      if (i % 5 == 0) sw_raw[2] = ~sw_raw[2];
      step();
      acc_x |= (switches_export ^ 8'h81) | sw_rise | sw_fall;
    end
    chk("bounce_no_change", 32'(acc_x), 32'h0);

    // 4: release, clear, clear colliding with set
    sw_raw = 8'h01;
    wait_export(8'h01, n, r, f, c, pc);
    chk("release_fall", 32'(f), 32'h80);
    chk("release_rise", 32'(r), 32'h00);
    step();
    chk("release_fall_one_cycle", 32'(sw_fall), 32'h00);
    clr_changed = 1'b1;
    step();
    clr_changed = 1'b0;
    chk("clear_changed", 32'(changed), 32'd0);
    step();
    chk("clear_changed_held", 32'(changed), 32'd0);
    clr_changed = 1'b1;
    sw_raw      = 8'h81;
    wait_export(8'h81, n, r, f, c, pc);
    clr_changed = 1'b0;
    chk("collide_before", 32'(pc), 32'd0);
    chk("collide_rise", 32'(r), 32'h80);
    chk("collide_set_wins", 32'(c), 32'd1);

    // 5: reset mid-count
    sw_raw = 8'h00;
    wait_export(8'h00, n, r, f, c, pc);
    chk("pre_reset_settle", 32'(n > 0), 32'd1);
    sw_raw = 8'hFF;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset_async");
    step();
    step();
    step();
    chk_all_zero("midreset_held");
    rst_n = 1'b1;
    wait_export(8'hFF, n, r, f, c, pc);
    chk("powerup_latency_ok", 32'(n >= 11 && n <= 15), 32'd1);
    chk("powerup_rise", 32'(r), 32'hFF);
    chk("powerup_changed", 32'(c), 32'd1);

    // 6: simultaneous multi-bit edges
    sw_raw = 8'h0F;
    wait_export(8'h0F, n, r, f, c, pc);
    chk("multi_pre_fall", 32'(f), 32'hF0);
    sw_raw = 8'hF0;
    wait_export(8'hF0, n, r, f, c, pc);
    chk("multi_rise", 32'(r), 32'hF0);
    chk("multi_fall", 32'(f), 32'h0F);
    step();
    chk("multi_one_cycle", 32'({sw_rise, sw_fall}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
